centering_streamer: RTL

- Producer side of the centered-sample interface that feeds the covariance block (GO_cov, Xcen1..Xcen4).
- Captures a frame of N raw 4-channel samples, computes the per-channel mean, then streams mean-subtracted samples, one per cycle.
- Pulses GO_cov so the covariance block starts in lockstep with the first centered sample.

---
 rtl/centering_streamer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/centering_streamer.sv
`default_nettype none
// ============================================================================
// Module   : centering_streamer
// Purpose  : Captures a frame of 4-channel samples, computes per-channel
//            means, then streams mean-subtracted samples to the covariance
//            block with a GO_cov start pulse aligned to the first sample.
// Options  : define CEN_ROUND_EN for round-half-up means (default is floor).
// Revision : 1.0 - initial release
// ============================================================================
module centering_streamer #(
    parameter int N_SAMPLES = 256,
    parameter int LOG2N     = 8,
    parameter int IN_W      = 24,
    parameter int OUT_W     = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             GO,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  X1,
    input  logic [IN_W-1:0]  X2,
    input  logic [IN_W-1:0]  X3,
    input  logic [IN_W-1:0]  X4,
    output logic [OUT_W-1:0] Xcen1,
    output logic [OUT_W-1:0] Xcen2,
    output logic [OUT_W-1:0] Xcen3,
    output logic [OUT_W-1:0] Xcen4,
    output logic             xcen_valid,
    output logic             GO_cov,
    output logic             busy,
    output logic             done
);

    localparam int NCH   = 4;
    localparam int ACC_W = IN_W + LOG2N;
    localparam int CNT_W = LOG2N + 1;
    localparam int EXT_W = OUT_W - IN_W;

    localparam logic [CNT_W-1:0] c_last_idx  = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] c_n_samples = CNT_W'(N_SAMPLES);
    localparam logic [ACC_W:0]   c_half      = (ACC_W+1)'(1) << (LOG2N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MEAN   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IN_W-1:0]       w_x [NCH];
    logic [NCH*IN_W-1:0]   w_wr_word;
    logic [NCH*IN_W-1:0]   r_ram [N_SAMPLES];
    logic [NCH*IN_W-1:0]   r_rd_data;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_last_accept;
    logic                  w_rd_en;
    logic                  w_stream_end;
    logic                  r_xcen_valid;
    logic                  r_go_cov;
    logic [OUT_W-1:0]      w_xcen [NCH];

    assign w_x[0]    = X1;
    assign w_x[1]    = X2;
    assign w_x[2]    = X3;
    assign w_x[3]    = X4;
    assign w_wr_word = {X4, X3, X2, X1};

    assign w_start       = (r_state == S_IDLE) && GO;
    assign in_ready      = (r_state == S_LOAD);
    assign w_accept      = in_valid && in_ready;
    assign w_last_accept = w_accept && (r_wr_cnt == c_last_idx);
    assign w_rd_en       = (r_state == S_STREAM) && (r_rd_cnt != c_n_samples);
    // STREAM holds one extra cycle so the last registered read is presented
    assign w_stream_end  = (r_state == S_STREAM) && (r_rd_cnt == c_n_samples);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (GO)            w_state_next = S_LOAD;
            S_LOAD:   if (w_last_accept) w_state_next = S_MEAN;
            S_MEAN:                      w_state_next = S_STREAM;
            S_STREAM: if (w_stream_end)  w_state_next = S_DONE;
            S_DONE:                      w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_start) begin
                r_wr_cnt <= '0;
            end else if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (r_state == S_MEAN) begin
                r_rd_cnt <= '0;
            end else if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // Sample RAM: no reset so it maps onto block memory with a registered read
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_ram[r_wr_cnt[LOG2N-1:0]] <= w_wr_word;
        end
        r_rd_data <= r_ram[r_rd_cnt[LOG2N-1:0]];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_xcen_valid <= 1'b0;
            r_go_cov     <= 1'b0;
        end else begin
            r_xcen_valid <= w_rd_en;
            r_go_cov     <= w_rd_en && (r_rd_cnt == '0);
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            logic signed [ACC_W-1:0] r_acc;
            logic [IN_W-1:0]         r_mean;
            logic signed [ACC_W:0]   w_acc_adj;
            logic signed [ACC_W:0]   w_acc_shr;
            logic [IN_W-1:0]         w_rd_x;
            logic [OUT_W-1:0]        w_diff;

`ifdef CEN_ROUND_EN
            assign w_acc_adj = {r_acc[ACC_W-1], r_acc} + c_half;
`else
            assign w_acc_adj = {r_acc[ACC_W-1], r_acc};
`endif
            assign w_acc_shr = w_acc_adj >>> LOG2N;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_acc  <= '0;
                    r_mean <= '0;
                end else begin
                    if (w_start) begin
                        r_acc <= '0;
                    end else if (w_accept) begin
                        r_acc <= r_acc + {{LOG2N{w_x[k][IN_W-1]}}, w_x[k]};
                    end
                    if (r_state == S_MEAN) begin
                        r_mean <= w_acc_shr[IN_W-1:0];
                    end
                end
            end

            assign w_rd_x = r_rd_data[k*IN_W +: IN_W];
            assign w_diff = {{EXT_W{w_rd_x[IN_W-1]}}, w_rd_x}
                          - {{EXT_W{r_mean[IN_W-1]}}, r_mean};
            // Gated by the valid flag so outputs read zero outside the stream
            assign w_xcen[k] = r_xcen_valid ? w_diff : '0;
        end
    endgenerate

    assign Xcen1      = w_xcen[0];
    assign Xcen2      = w_xcen[1];
    assign Xcen3      = w_xcen[2];
    assign Xcen4      = w_xcen[3];
    assign xcen_valid = r_xcen_valid;
    assign GO_cov     = r_go_cov;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire
